// File: rtl/pong_pkg.sv
// Shared types, coordinate widths and a saturating clamp for the pong game controller.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int CALC_W = 12;

  function automatic logic [CALC_W-1:0] clampRange(
    input logic [CALC_W-1:0] value,
    input logic [CALC_W-1:0] lo,
    input logic [CALC_W-1:0] hi
  );
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/pong_frame_tick.sv
// Registers vsync and emits a one-cycle pulse on the cycle after its rising edge.
module pong_frame_tick (
  input  logic clock_i,
  input  logic reset_i,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q;
  logic tick_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      tick_q  <= vsync_i & ~vsync_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pong_sequencer.sv
// Frame-rate pong controller: serve/play/miss/over sequencing plus paddle and puck motion.
// Build with PONG_ATTRACT_EN defined to let attract_in hand the paddle to an auto-tracker.
module pong_sequencer
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = 1024,
  parameter int SCREEN_H     = 768,
  parameter int PADDLE_W     = 16,
  parameter int PADDLE_H     = 128,
  parameter int PUCK_SIZE    = 64,
  parameter int PADDLE_STEP  = 4,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30
) (
  input  logic           vclock_in,
  input  logic           reset_in,
  input  logic           vsync_in,
  input  logic           up_in,
  input  logic           down_in,
  input  logic [3:0]     pspeed_in,
  input  logic           attract_in,
  output logic [Y_W-1:0] paddle_y_out,
  output logic [X_W-1:0] puck_x_out,
  output logic [Y_W-1:0] puck_y_out,
  output logic [1:0]     state_out,
  output logic [1:0]     lives_out,
  output logic           frame_tick_out
);

  localparam logic [CALC_W-1:0] X_MAX     = CALC_W'(SCREEN_W - PUCK_SIZE);
  localparam logic [CALC_W-1:0] Y_MAX     = CALC_W'(SCREEN_H - PUCK_SIZE);
  localparam logic [CALC_W-1:0] PAD_MAX   = CALC_W'(SCREEN_H - PADDLE_H);
  localparam logic [CALC_W-1:0] PAD_LEFT  = CALC_W'(PADDLE_W);
  localparam logic [CALC_W-1:0] PAD_HGT   = CALC_W'(PADDLE_H);
  localparam logic [CALC_W-1:0] PUCK_SZ   = CALC_W'(PUCK_SIZE);
  localparam logic [CALC_W-1:0] STEP      = CALC_W'(PADDLE_STEP);
  localparam logic [CALC_W-1:0] HALF_PUCK = CALC_W'(PUCK_SIZE / 2);
  localparam logic [CALC_W-1:0] HALF_PAD  = CALC_W'(PADDLE_H / 2);
  localparam logic [CALC_W-1:0] ZERO      = '0;

  localparam logic [Y_W-1:0] PAD_INIT  = Y_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [X_W-1:0] PUCK_X0   = X_W'((SCREEN_W - PUCK_SIZE) / 2);
  localparam logic [Y_W-1:0] PUCK_Y0   = Y_W'((SCREEN_H - PUCK_SIZE) / 2);
  localparam logic [1:0]     LIVES0    = 2'(LIVES);
  localparam logic [7:0]     SERVE_END = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]     MISS_END  = 8'(MISS_FRAMES - 1);

  game_state_t     state_q;
  logic [1:0]      lives_q;
  logic [Y_W-1:0]  paddleY_q;
  logic [X_W-1:0]  puckX_q;
  logic [Y_W-1:0]  puckY_q;
  logic            dx_q;
  logic            dy_q;
  logic [7:0]      frameCnt_q;
  logic            frameTick;
  logic            attractMode;

  logic [CALC_W-1:0] padW, pxW, pyW, sW;
  logic [CALC_W-1:0] target;
  logic [CALC_W-1:0] paddleY_d;
  logic [CALC_W-1:0] puckY_d;
  logic [X_W-1:0]    puckX_d;
  logic              dx_d;
  logic              dy_d;
  logic              missed;

  pong_frame_tick uFrameTick (
    .clock_i (vclock_in),
    .reset_i (reset_in),
    .vsync_i (vsync_in),
    .tick_o  (frameTick)
  );

`ifdef PONG_ATTRACT_EN
  assign attractMode = attract_in;
`else
  logic unusedAttract;
  assign unusedAttract = attract_in;
  assign attractMode   = 1'b0;
`endif

  assign padW = CALC_W'(paddleY_q);
  assign pxW  = CALC_W'(puckX_q);
  assign pyW  = CALC_W'(puckY_q);
  assign sW   = CALC_W'(pspeed_in);

  // dx_q/dy_q high means moving right/down; everything is 12-bit so nothing wraps.
  always_comb begin
    target    = ZERO;
    paddleY_d = padW;
    puckY_d   = pyW;
    puckX_d   = puckX_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    missed    = 1'b0;

    if (attractMode) begin
      target = (pyW + HALF_PUCK < HALF_PAD) ? ZERO
             : clampRange(pyW + HALF_PUCK - HALF_PAD, ZERO, PAD_MAX);
      if (target > padW) begin
        paddleY_d = (target - padW > STEP) ? padW + STEP : target;
      end else begin
        paddleY_d = (padW - target > STEP) ? padW - STEP : target;
      end
    end else if (up_in && !down_in) begin
      paddleY_d = (padW < STEP) ? ZERO : padW - STEP;
    end else if (down_in && !up_in) begin
      paddleY_d = clampRange(padW + STEP, ZERO, PAD_MAX);
    end

    if (!dy_q) begin
      if (pyW < sW) begin
        puckY_d = ZERO;
        dy_d    = 1'b1;
      end else begin
        puckY_d = pyW - sW;
      end
    end else if (pyW + sW > Y_MAX) begin
      puckY_d = Y_MAX;
      dy_d    = 1'b0;
    end else begin
      puckY_d = pyW + sW;
    end

    // The hit window uses this tick's moved paddle and moved puck row.
    if (dx_q) begin
      if (pxW + sW > X_MAX) begin
        puckX_d = X_W'(X_MAX);
        dx_d    = 1'b0;
      end else begin
        puckX_d = X_W'(pxW + sW);
      end
    end else if (pxW < PAD_LEFT + sW) begin
      if ((puckY_d + PUCK_SZ > paddleY_d) && (puckY_d < paddleY_d + PAD_HGT)) begin
        puckX_d = X_W'(PAD_LEFT);
        dx_d    = 1'b1;
      end else begin
        puckX_d = '0;
        missed  = 1'b1;
      end
    end else begin
      puckX_d = X_W'(pxW - sW);
    end
  end

  // Game state only advances on the frame tick, so outputs hold for a whole frame.
  always_ff @(posedge vclock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= SERVE;
      lives_q    <= LIVES0;
      paddleY_q  <= PAD_INIT;
      puckX_q    <= PUCK_X0;
      puckY_q    <= PUCK_Y0;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      frameCnt_q <= '0;
    end else if (frameTick) begin
      if (state_q != OVER) begin
        paddleY_q <= Y_W'(paddleY_d);
      end
      case (state_q)
        SERVE: begin
          if (frameCnt_q == SERVE_END) begin
            frameCnt_q <= '0;
            state_q    <= PLAY;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
          end else begin
            frameCnt_q <= frameCnt_q + 8'd1;
          end
        end
        PLAY: begin
          if (pspeed_in != 4'd0) begin
            puckX_q <= puckX_d;
            puckY_q <= Y_W'(puckY_d);
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            if (missed) begin
              state_q    <= MISS;
              frameCnt_q <= '0;
              if (!attractMode) begin
                lives_q <= lives_q - 2'd1;
              end
            end
          end
        end
        MISS: begin
          if (frameCnt_q == MISS_END) begin
            frameCnt_q <= '0;
            if (lives_q == 2'd0) begin
              state_q <= OVER;
            end else begin
              state_q <= SERVE;
              puckX_q <= PUCK_X0;
              puckY_q <= PUCK_Y0;
            end
          end else begin
            frameCnt_q <= frameCnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign paddle_y_out   = paddleY_q;
  assign puck_x_out     = puckX_q;
  assign puck_y_out     = puckY_q;
  assign state_out      = state_q;
  assign lives_out      = lives_q;
  assign frame_tick_out = frameTick;

endmodule

// File: tb/tb_pong_sequencer.sv
// Self-checking bench for pong_sequencer: directed phases plus a randomized play phase
// compared frame by frame against a rule-level game model.
module tb_pong_sequencer;

`ifdef PONG_ATTRACT_EN
  localparam bit ATTRACT_ON = 1'b1;
`else
  localparam bit ATTRACT_ON = 1'b0;
`endif

  logic        vclock = 1'b0;
  logic        reset;
  logic        vsync;
  logic        up;
  logic        down;
  logic [3:0]  pspeed;
  logic        attract;
  logic [9:0]  paddleY;
  logic [10:0] puckX;
  logic [9:0]  puckY;
  logic [1:0]  state;
  logic [1:0]  lives;
  logic        frameTick;

  int checkCount = 0;
  int passCount  = 0;

  int mState, mLives, mPad, mPx, mPy, mDx, mDy, mCnt;

  pong_sequencer dut (
    .vclock_in      (vclock),
    .reset_in       (reset),
    .vsync_in       (vsync),
    .up_in          (up),
    .down_in        (down),
    .pspeed_in      (pspeed),
    .attract_in     (attract),
    .paddle_y_out   (paddleY),
    .puck_x_out     (puckX),
    .puck_y_out     (puckY),
    .state_out      (state),
    .lives_out      (lives),
    .frame_tick_out (frameTick)
  );

  always #5 vclock = ~vclock;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    mState = 0; mLives = 3; mPad = 320; mPx = 480; mPy = 352;
    mDx = 1; mDy = 1; mCnt = 0;
  endtask

  // Game rules at frame granularity, in plain integer arithmetic.
  task automatic modelTick(input bit u, input bit d, input int s, input bit att);
    bit attEff;
    int tgt, ny;
    attEff = att && ATTRACT_ON;
    if (mState != 3) begin
      if (attEff) begin
        tgt = mPy + 32 - 64;
        if (tgt < 0) tgt = 0;
        if (tgt > 640) tgt = 640;
        if (tgt > mPad) mPad = mPad + ((tgt - mPad > 4) ? 4 : tgt - mPad);
        else            mPad = mPad - ((mPad - tgt > 4) ? 4 : mPad - tgt);
      end else if (u && !d) begin
        mPad = (mPad < 4) ? 0 : mPad - 4;
      end else if (d && !u) begin
        mPad = (mPad + 4 > 640) ? 640 : mPad + 4;
      end
    end
    case (mState)
      0: begin
        if (mCnt == 59) begin mCnt = 0; mState = 1; mDx = 1; mDy = 1; end
        else mCnt++;
      end
      1: if (s != 0) begin
        if (mDy < 0) begin
          if (mPy < s) begin ny = 0; mDy = 1; end else ny = mPy - s;
        end else begin
          if (mPy + s > 704) begin ny = 704; mDy = -1; end else ny = mPy + s;
        end
        if (mDx > 0) begin
          if (mPx + s > 960) begin mPx = 960; mDx = -1; end else mPx = mPx + s;
        end else if (mPx < 16 + s) begin
          if (ny + 64 > mPad && ny < mPad + 128) begin
            mPx = 16; mDx = 1;
          end else begin
            mPx = 0; mState = 2; mCnt = 0;
            if (!attEff) mLives--;
          end
        end else begin
          mPx = mPx - s;
        end
        mPy = ny;
      end
      2: begin
        if (mCnt == 29) begin
          mCnt = 0;
          if (mLives == 0) mState = 3;
          else begin mState = 0; mPx = 480; mPy = 352; end
        end else mCnt++;
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".state"},   32'(state),   mState);
    checkVal({tag, ".lives"},   32'(lives),   mLives);
    checkVal({tag, ".paddleY"}, 32'(paddleY), mPad);
    checkVal({tag, ".puckX"},   32'(puckX),   mPx);
    checkVal({tag, ".puckY"},   32'(puckY),   mPy);
  endtask

  // One video frame: vsync pulse, then the model advances by the same tick.
  task automatic applyStimulus(input bit u, input bit d, input int s, input bit att, input bit chkTick);
    @(negedge vclock);
    up = u; down = d; pspeed = 4'(s); attract = att; vsync = 1'b1;
    @(negedge vclock);
    if (chkTick) checkVal("tick.pulse", 32'(frameTick), 1);
    @(negedge vclock);
    if (chkTick) checkVal("tick.single", 32'(frameTick), 0);
    vsync = 1'b0;
    @(negedge vclock);
    modelTick(u, d, s, att);
  endtask

  task automatic doReset();
    @(negedge vclock);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("reset");
    checkVal("reset.tick", 32'(frameTick), 0);
    @(negedge vclock);
    reset = 1'b0;
  endtask

  initial begin
    int savedPad, savedPx, savedPy;
    int s, pc, tc;
    bit u, d;
    reset = 1'b1; vsync = 1'b0; up = 1'b0; down = 1'b0; pspeed = 4'd0; attract = 1'b0;
    modelReset();
    repeat (3) @(negedge vclock);
    checkOutput("init");
    checkVal("init.tick", 32'(frameTick), 0);
    reset = 1'b0;

    // Serve countdown into play.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b0, 4, 1'b0, i < 3);
      checkOutput("serve");
      if (i == 58) checkVal("serve.tick59.state", 32'(state), 0);
    end
    checkVal("serve.play.state", 32'(state), 1);
    checkVal("serve.play.x", 32'(puckX), 480);
    checkVal("serve.play.y", 32'(puckY), 352);
    applyStimulus(1'b0, 1'b0, 4, 1'b0, 1'b0);
    checkOutput("firstMove");
    checkVal("firstMove.x", 32'(puckX), 484);
    checkVal("firstMove.y", 32'(puckY), 356);

    // Paddle saturation at the top with the puck parked (speed 0).
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
      checkOutput("paddleUp");
    end
    checkVal("paddleUp.sat", 32'(paddleY), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    checkVal("paddleDown.20", 32'(paddleY), 20);
    applyStimulus(1'b1, 1'b1, 0, 1'b0, 1'b0);
    checkVal("paddleBoth.hold", 32'(paddleY), 20);
    checkVal("parked.x", 32'(puckX), 484);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("paddleTop");

    // Puck bounces around at speed 8 until the first miss.
    for (int i = 0; i < 800 && mState != 2; i++) begin
      applyStimulus(1'b0, 1'b0, 8, 1'b0, 1'b0);
      checkOutput("seekMiss");
    end
    checkVal("miss.state", 32'(state), 2);
    checkVal("miss.lives", 32'(lives), 2);
    checkVal("miss.x", 32'(puckX), 0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 8, 1'b0, 1'b0);
      checkOutput("missHold");
    end
    checkVal("reserve.state", 32'(state), 0);
    checkVal("reserve.x", 32'(puckX), 480);
    checkVal("reserve.y", 32'(puckY), 352);

    // Run out the remaining lives, then hammer buttons in OVER.
    for (int i = 0; i < 3000 && mState != 3; i++) begin
      applyStimulus(1'b0, 1'b0, 15, 1'b0, 1'b0);
      checkOutput("seekOver");
    end
    checkVal("over.state", 32'(state), 3);
    checkVal("over.lives", 32'(lives), 0);
    savedPad = mPad; savedPx = mPx; savedPy = mPy;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'b0);
      checkOutput("overFrozen");
    end
    checkVal("overFrozen.paddle", 32'(paddleY), savedPad);
    checkVal("overFrozen.x", 32'(puckX), savedPx);
    checkVal("overFrozen.y", 32'(puckY), savedPy);

    // Reset arriving while vsync is high.
    @(negedge vclock);
    vsync = 1'b1;
    @(negedge vclock);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("midReset");
    checkVal("midReset.lives", 32'(lives), 3);
    checkVal("midReset.tick", 32'(frameTick), 0);
    vsync = 1'b0;
    @(negedge vclock);
    reset = 1'b0;

    // Randomized play with a loosely tracking player.
    for (int i = 0; i < 1500; i++) begin
      if (mState == 3) doReset();
      s  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      pc = mPad + 64;
      tc = mPy + 32;
      u  = (pc > tc + 8) || ($urandom_range(0, 7) == 0);
      d  = (pc < tc - 8) || ($urandom_range(0, 7) == 0);
      applyStimulus(u, d, s, ($urandom_range(0, 3) == 0), 1'b0);
      checkOutput("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
